// File: rtl/alu_pipe.sv
// alu_pipe: handshaked execute-stage ALU (logic/arith, 2-stage multiply, iterative restoring divide).
// Latency accept->out_valid: 1 single-cycle/illegal/div-by-zero, 3 MUL, WIDTH+1 DIV; one op in flight.
// Backpressure: in_ready only while idle; no output stall, consumer samples on the out_valid pulse.
// Optional divider compiled in with `define ALU_DIV_EN; without it DIV is reported as an illegal opcode.
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           opcode,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   result,
    output logic [3:0]           nzcv,
    output logic                 err
);

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_MUL  = 5'b00011;
    localparam logic [4:0] OP_DIV  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_NOT  = 5'b01100;
    localparam logic [4:0] OP_XOR  = 5'b01101;
    localparam logic [4:0] OP_NAND = 5'b01110;
    localparam logic [4:0] OP_NOR  = 5'b01111;
    localparam logic [4:0] OP_XNOR = 5'b10000;

    // Multiplier splits operand B into a low and a high slice (handles odd WIDTH).
    localparam int HL = WIDTH / 2;
    localparam int HH = WIDTH - HL;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL1,
        S_MUL2,
        S_DIV,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [2*WIDTH-1:0]     result_q;
    logic [3:0]             nzcv_q;
    logic                   err_q;

    // Captured operands and the staged response waiting for the DONE cycle.
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic [2*WIDTH-1:0]     stg_res_q;
    logic [3:0]             stg_nzcv_q;
    logic                   stg_err_q;

    // Multiplier partial products registered between MUL1 and MUL2.
    logic [WIDTH+HL-1:0]    pp_lo_q;
    logic [WIDTH+HH-1:0]    pp_hi_q;
    logic [2*WIDTH-1:0]     prod_d;

    // Single-cycle evaluation of the operation presented at the input.
    logic [WIDTH:0]         add_w;
    logic [WIDTH:0]         sub_w;
    logic [WIDTH-1:0]       lo_d;
    logic                   c_d;
    logic                   v_d;
    logic                   bad_d;
    logic                   go_mul_d;
    logic [2*WIDTH-1:0]     sc_res_d;
    logic [3:0]             sc_nzcv_d;
    logic                   sc_err_d;

`ifdef ALU_DIV_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic                   go_div_d;
    logic                   div_zero_d;
    logic [WIDTH-1:0]       rem_q;
    logic [WIDTH-1:0]       quo_q;
    logic [CW-1:0]          cnt_q;
    logic [WIDTH:0]         div_trial;
    logic [WIDTH-1:0]       rem_d;
    logic [WIDTH-1:0]       quo_d;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign nzcv      = nzcv_q;
    assign err       = err_q;

    // Decode the incoming opcode and evaluate all single-cycle outcomes (incl. illegal / div-by-zero).
    always_comb begin
        add_w    = {1'b0, src1} + {1'b0, src2};
        sub_w    = {1'b0, src1} - {1'b0, src2};
        lo_d     = '0;
        c_d      = 1'b0;
        v_d      = 1'b0;
        bad_d    = 1'b0;
        go_mul_d = 1'b0;
`ifdef ALU_DIV_EN
        go_div_d   = 1'b0;
        div_zero_d = 1'b0;
`endif
        case (opcode)
            OP_ADD: begin
                lo_d = add_w[WIDTH-1:0];
                c_d  = add_w[WIDTH];
                v_d  = (src1[WIDTH-1] == src2[WIDTH-1]) && (add_w[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SUB: begin
                lo_d = sub_w[WIDTH-1:0];
                // Top bit of the widened difference is the borrow; carry means no borrow.
                c_d  = ~sub_w[WIDTH];
                v_d  = (src1[WIDTH-1] != src2[WIDTH-1]) && (sub_w[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_AND:  lo_d = src1 & src2;
            OP_OR:   lo_d = src1 | src2;
            OP_NOT:  lo_d = ~src1;
            OP_XOR:  lo_d = src1 ^ src2;
            OP_NAND: lo_d = ~(src1 & src2);
            OP_NOR:  lo_d = ~(src1 | src2);
            OP_XNOR: lo_d = ~(src1 ^ src2);
            OP_MUL:  go_mul_d = 1'b1;
            OP_DIV: begin
`ifdef ALU_DIV_EN
                if (src2 == '0) begin
                    div_zero_d = 1'b1;
                end else begin
                    go_div_d = 1'b1;
                end
`else
                bad_d = 1'b1;
`endif
            end
            default: bad_d = 1'b1;
        endcase

        sc_res_d  = {{WIDTH{1'b0}}, lo_d};
        sc_nzcv_d = {lo_d[WIDTH-1], (lo_d == '0), c_d, v_d};
        sc_err_d  = bad_d;
        if (bad_d) begin
            sc_res_d  = '0;
            sc_nzcv_d = 4'b0000;
        end
`ifdef ALU_DIV_EN
        // Division by zero: quotient saturates to all-ones, remainder is the dividend.
        if (div_zero_d) begin
            sc_res_d  = {src1, {WIDTH{1'b1}}};
            sc_nzcv_d = 4'b0000;
            sc_err_d  = 1'b1;
        end
`endif
    end

    // Second multiply stage: align the high-slice partial product and sum.
    always_comb begin
        prod_d = {{HH{1'b0}}, pp_lo_q} + ({{HL{1'b0}}, pp_hi_q} << HL);
    end

`ifdef ALU_DIV_EN
    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        div_trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, b_q};
        if (!div_trial[WIDTH]) begin
            rem_d = div_trial[WIDTH-1:0];
        end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        end
        quo_d = {quo_q[WIDTH-2:0], ~div_trial[WIDTH]};
    end
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            nzcv_q      <= 4'b0000;
            err_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            stg_res_q   <= '0;
            stg_nzcv_q  <= 4'b0000;
            stg_err_q   <= 1'b0;
            pp_lo_q     <= '0;
            pp_hi_q     <= '0;
`ifdef ALU_DIV_EN
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= src1;
                        b_q        <= src2;
                        in_ready_q <= 1'b0;
                        if (go_mul_d) begin
                            state_q <= S_MUL1;
`ifdef ALU_DIV_EN
                        end else if (go_div_d) begin
                            rem_q   <= '0;
                            quo_q   <= src1;
                            cnt_q   <= '0;
                            state_q <= S_DIV;
`endif
                        end else begin
                            stg_res_q  <= sc_res_d;
                            stg_nzcv_q <= sc_nzcv_d;
                            stg_err_q  <= sc_err_d;
                            state_q    <= S_DONE;
                        end
                    end
                end
                S_MUL1: begin
                    pp_lo_q <= {{HL{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q[HL-1:0]};
                    pp_hi_q <= {{HH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q[WIDTH-1:HL]};
                    state_q <= S_MUL2;
                end
                S_MUL2: begin
                    stg_res_q  <= prod_d;
                    stg_nzcv_q <= {prod_d[2*WIDTH-1], (prod_d == '0), 2'b00};
                    stg_err_q  <= 1'b0;
                    state_q    <= S_DONE;
                end
`ifdef ALU_DIV_EN
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        stg_res_q  <= {rem_d, quo_d};
                        stg_nzcv_q <= {1'b0, (quo_d == '0), 2'b00};
                        stg_err_q  <= 1'b0;
                        state_q    <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    out_valid_q <= 1'b1;
                    result_q    <= stg_res_q;
                    nzcv_q      <= stg_nzcv_q;
                    err_q       <= stg_err_q;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    in_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized + directed scoreboard bench for alu_pipe (WIDTH=16).
// Expected responses come from an arithmetic reference model and are queued at issue time.
// A negedge monitor pops and compares value, flags, error and arrival cycle on every out_valid.
module tb_alu_pipe;

    localparam int W = 16;

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_MUL  = 5'b00011;
    localparam logic [4:0] OP_DIV  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_NOT  = 5'b01100;
    localparam logic [4:0] OP_XOR  = 5'b01101;
    localparam logic [4:0] OP_NAND = 5'b01110;
    localparam logic [4:0] OP_NOR  = 5'b01111;
    localparam logic [4:0] OP_XNOR = 5'b10000;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      opcode;
    logic [W-1:0]    src1;
    logic [W-1:0]    src2;
    logic            out_valid;
    logic [2*W-1:0]  result;
    logic [3:0]      nzcv;
    logic            err;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .result    (result),
        .nzcv      (nzcv),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  nzcv;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on the documented rules.
    function automatic exp_t model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint ua, ub, lo, p;
        int     sa, sbv, s;
        logic   n, z, c, v, logic_op;
        ua = a; ub = b;
        sa = $signed(a); sbv = $signed(b);
        e.res = 0; e.nzcv = 0; e.err = 0; e.due = 1;
        lo = 0; c = 0; v = 0; logic_op = 1;
        case (op)
            OP_ADD: begin
                lo = (ua + ub) % 65536; c = (ua + ub) >= 65536;
                s = sa + sbv; v = (s > 32767) || (s < -32768);
            end
            OP_SUB: begin
                lo = (ua - ub + 65536) % 65536; c = (ua >= ub);
                s = sa - sbv; v = (s > 32767) || (s < -32768);
            end
            OP_AND:  lo = a & b;
            OP_OR:   lo = a | b;
            OP_NOT:  lo = 16'(~a);
            OP_XOR:  lo = a ^ b;
            OP_NAND: lo = 16'(~(a & b));
            OP_NOR:  lo = 16'(~(a | b));
            OP_XNOR: lo = 16'(~(a ^ b));
            OP_MUL: begin
                logic_op = 0;
                p = ua * ub;
                e.res = 32'(p);
                e.nzcv = {p >= 64'd2147483648, p == 0, 2'b00};
                e.due = 3;
            end
`ifdef ALU_DIV_EN
            OP_DIV: begin
                logic_op = 0;
                if (ub == 0) begin
                    e.res = 32'(ua * 65536 + 65535);
                    e.err = 1;
                end else begin
                    e.res = 32'((ua % ub) * 65536 + ua / ub);
                    e.nzcv = {1'b0, (ua / ub) == 0, 2'b00};
                    e.due = W + 1;
                end
            end
`endif
            default: begin
                logic_op = 0;
                e.err = 1;
            end
        endcase
        if (logic_op) begin
            n = lo >= 32768;
            z = lo == 0;
            e.res = 32'(lo);
            e.nzcv = {n, z, c, v};
        end
        return e;
    endfunction

    // Monitor: every out_valid must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid: got out_valid=1 expected no response (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("nzcv", {28'd0, nzcv}, {28'd0, e.nzcv});
                    check("err", {31'd0, err}, {31'd0, e.err});
                    check("latency_cycle", cyc, e.due);
                end
            end
        end
    end

    // Issue one op from a negedge; returns on the negedge after the accept edge.
    task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   guard;
        guard = 0;
        while (in_ready !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: got in_ready=%b expected 1 within 100 cycles", in_ready);
                return;
            end
        end
        e = model(op, a, b);
        e.due = cyc + 1 + e.due;
        sb.push_back(e);
        opcode = op; src1 = a; src2 = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic logic [15:0] pick_operand();
        logic [15:0] corners [5];
        corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'h7FFF;
        corners[3] = 16'h8000; corners[4] = 16'hFFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    initial begin
        logic [4:0]  ops [12];
        logic [4:0]  op;
        logic [15:0] a, b;
        exp_t        e;
        int          guard;
        int          nwait;

        ops[0] = OP_ADD;  ops[1] = OP_SUB;  ops[2]  = OP_MUL;  ops[3]  = OP_DIV;
        ops[4] = OP_AND;  ops[5] = OP_OR;   ops[6]  = OP_NOT;  ops[7]  = OP_XOR;
        ops[8] = OP_NAND; ops[9] = OP_NOR;  ops[10] = OP_XNOR; ops[11] = 5'b11111;

        rst = 1'b1; in_valid = 1'b0; opcode = '0; src1 = '0; src2 = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_nzcv", {28'd0, nzcv}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases, including the documented boundaries.
        issue(OP_ADD, 16'h7FFF, 16'h0001);
        issue(OP_SUB, 16'h0003, 16'h0005);
        issue(OP_SUB, 16'h0005, 16'h0005);
        issue(OP_ADD, 16'hFFFF, 16'h0001);
        issue(OP_DIV, 16'd100, 16'd7);
        issue(OP_DIV, 16'h1234, 16'h0000);
        issue(OP_NOT, 16'h00FF, 16'h1234);
        issue(5'b11111, 16'h1111, 16'h2222);

        // MUL with in_valid held high while busy: exactly one accept, ready low for 3 cycles.
        guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        e = model(OP_MUL, 16'hFFFF, 16'hFFFF);
        e.due = cyc + 1 + e.due;
        sb.push_back(e);
        opcode = OP_MUL; src1 = 16'hFFFF; src2 = 16'hFFFF; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("hold_in_ready", {31'd0, in_ready}, {31'd0, (k == 4)});
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Reset in the middle of a multi-cycle op: discarded, no out_valid.
`ifdef ALU_DIV_EN
        issue(OP_DIV, 16'hFFFF, 16'h0003);
        nwait = 7;
`else
        issue(OP_MUL, 16'h1234, 16'h5678);
        nwait = 0;
`endif
        repeat (nwait) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        // An in_valid coinciding with rst must not be accepted.
        opcode = OP_ADD; src1 = 16'h0001; src2 = 16'h0001; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("midop_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midop_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midop_rst_result", result, 32'd0);
        check("midop_rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        issue(OP_XNOR, 16'hF0F0, 16'h0FF0);

        // Randomized traffic with idle gaps.
        for (int i = 0; i < 150; i++) begin
            op = ops[$urandom_range(0, 11)];
            if (op == 5'b11111 && $urandom_range(0, 1) == 1) op = 5'($urandom_range(17, 31));
            a = pick_operand();
            b = pick_operand();
            if (op == OP_DIV && $urandom_range(0, 7) == 0) b = 16'h0000;
            issue(op, a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Drain outstanding responses.
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d responses outstanding expected 0", sb.size());
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
